rx_timer: RTL and testbench
===========================

RX_TIMER -- requirements
Module: rx_timer

Interface
REQ-001: Parameter CLKS_PER_BIT, default 10, clock cycles per serial bit period; legal range 2..255.
REQ-002: Parameter BITS_PER_PACKET, default 9, bit periods per packet (8 data + stop); legal range 1..255.
REQ-003: clk  input  1  system clock; the single clock for the block, all state changes on its rising edge.
REQ-004: n_rst  input  1  reset; synchronous and active-low.
REQ-005: enable_timer  input  1  level from receiver control unit; high while a packet is being read.
REQ-006: shift_strobe  output  1  one-cycle pulse telling the shift register to sample serial_in.
REQ-007: packet_done  output  1  level; high once the last bit period of the packet has elapsed.

Function
REQ-008: The block SHALL hold clk_cnt (width clog2(CLKS_PER_BIT)) and bit_cnt (width clog2(BITS_PER_PACKET+1)), both resetting to 0.
REQ-009: All outputs SHALL be registered; no combinational path from enable_timer to any output.
REQ-010: On an edge with enable_timer=1 and packet_done=0: clk_cnt <= (clk_cnt==CLKS_PER_BIT-1) ? 0 : clk_cnt+1.
REQ-011: On that same edge, shift_strobe <= (clk_cnt==CLKS_PER_BIT-1); otherwise shift_strobe <= 0, so every strobe lasts exactly one cycle.
REQ-012: bit_cnt SHALL increment on every edge that sets shift_strobe.
REQ-013: packet_done SHALL be set on the edge where clk_cnt==CLKS_PER_BIT-1 and bit_cnt==BITS_PER_PACKET-1, coincident with the final shift_strobe.
REQ-014: Latency: with enable_timer high from edge 1, strobes are high after edges k*CLKS_PER_BIT, k=1..BITS_PER_PACKET; packet_done is high from edge CLKS_PER_BIT*BITS_PER_PACKET.
REQ-015: While packet_done=1 and enable_timer=1, counters SHALL hold, shift_strobe SHALL stay 0 and packet_done SHALL stay 1.
REQ-016: On any edge with enable_timer=0: clk_cnt, bit_cnt, shift_strobe and packet_done SHALL all clear to 0.
REQ-017: enable_timer deasserted mid-packet SHALL abort: no packet_done, state cleared; re-assertion starts a full fresh packet.
REQ-018: A one-cycle enable_timer low between packets is sufficient to rearm the block.
REQ-019: States, implicit in the counters: IDLE (enable low), COUNTING, DONE (packet_done held); IDLE->COUNTING on enable high, COUNTING->DONE per REQ-013, any->IDLE on enable low.

Reset
REQ-020: n_rst=0 sampled at a rising edge SHALL clear clk_cnt, bit_cnt, shift_strobe and packet_done to 0, overriding enable_timer.
REQ-021: Reset mid-packet SHALL discard progress; after release with enable_timer high, the first strobe follows CLKS_PER_BIT edges later.
REQ-022: No output SHALL change asynchronously to clk.

Structure
REQ-023: Defaults UART_CLKS_PER_BIT=10 and UART_BITS_PER_PACKET=9 SHALL live in shared package uart_pkg, used by rx_timer and the receiver top level.
REQ-024: Both counters SHALL be instances of one sub-module flex_counter (synchronous active-low reset, clear, count_enable, rollover_val, count_out, rollover_flag).
REQ-025: The bit-period counter's rollover_flag SHALL drive the bit counter's count_enable.

Verification
REQ-026: Reset: n_rst=0 for 2 edges with enable_timer=1 -> shift_strobe=0, packet_done=0 throughout and after.
REQ-027: Full packet, defaults: enable high from edge 1 -> strobes after edges 10,20,...,90 (9 pulses, each 1 cycle); packet_done high from edge 90.
REQ-028: Hold after done: enable kept high for 30 edges past 90 -> no further strobes, packet_done stays 1; enable low 1 edge -> packet_done 0.
REQ-029: Abort: enable low at edge 45 -> no packet_done; re-enable at edge 47 -> first strobe after edge 56, packet_done at edge 136.
REQ-030: Reset mid-packet: n_rst=0 at edge 33, released at 34, enable high -> next strobe after edge 44.
REQ-031: CLKS_PER_BIT=4, BITS_PER_PACKET=2: enable from edge 1 -> strobes after edges 4 and 8, packet_done from edge 8.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receiver definitions.
//   UART_CLKS_PER_BIT    : system clocks per serial bit period
//   UART_BITS_PER_PACKET : bit periods per packet (8 data + stop)
//   cnt_width()          : counter width for a count range, never below 1
package uart_pkg;

  localparam int UART_CLKS_PER_BIT    = 10;
  localparam int UART_BITS_PER_PACKET = 9;

  // $clog2 returns 0 for n<=1, which is not a legal vector width.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/flex_counter.sv
// Generic rollover counter.
//   clk           : rising-edge clock
//   n_rst         : synchronous active-low reset
//   clear         : synchronous clear to 0 (beats count_enable)
//   count_enable  : advance by one this edge
//   rollover_val  : last value before the count wraps to 0
//   count_out     : current count
//   rollover_flag : high while the count is enabled and sitting on
//                   rollover_val, i.e. this edge wraps the counter
module flex_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_val,
  output logic [WIDTH-1:0] count_out,
  output logic             rollover_flag
);

  assign rollover_flag = count_enable && (count_out == rollover_val);

  always_ff @(posedge clk) begin
    if (!n_rst || clear)
      count_out <= '0;
    else if (count_enable)
      count_out <= rollover_flag ? '0 : count_out + WIDTH'(1);
  end

endmodule

// File: rtl/rx_timer.sv
// UART receive bit timer.
//   clk          : system clock, all state on its rising edge
//   n_rst        : synchronous active-low reset
//   enable_timer : high while the control unit is reading a packet
//   shift_strobe : registered one-cycle pulse at the end of each bit period
//   packet_done  : registered level, high once the last bit period elapsed
//                  and held until enable_timer drops
// State is implicit: enable low = idle, counting while enable high and
// packet_done low, done while packet_done high.
module rx_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT    = UART_CLKS_PER_BIT,
  parameter int BITS_PER_PACKET = UART_BITS_PER_PACKET
) (
  input  logic clk,
  input  logic n_rst,
  input  logic enable_timer,
  output logic shift_strobe,
  output logic packet_done
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam int BW = cnt_width(BITS_PER_PACKET + 1);

  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_PACKET - 1);

  logic          counting;
  logic [CW-1:0] clk_cnt;
  logic [BW-1:0] bit_cnt;
  logic          bit_tick;   // this edge ends a bit period
  logic          last_bit;   // this edge ends the final bit period

  assign counting = enable_timer && !packet_done;

  // Bit-period counter: wraps every CLKS_PER_BIT enabled edges.
  flex_counter #(.WIDTH(CW)) u_clk_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (!enable_timer),
    .count_enable  (counting),
    .rollover_val  (CLK_LAST),
    .count_out     (clk_cnt),
    .rollover_flag (bit_tick)
  );

  // Bit counter: its rollover marks the final bit of the packet. It wraps
  // to 0 on that same edge and then holds, since counting stops at done.
  flex_counter #(.WIDTH(BW)) u_bit_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (!enable_timer),
    .count_enable  (bit_tick),
    .rollover_val  (BIT_LAST),
    .count_out     (bit_cnt),
    .rollover_flag (last_bit)
  );

  always_ff @(posedge clk) begin
    if (!n_rst || !enable_timer) begin
      shift_strobe <= 1'b0;
      packet_done  <= 1'b0;
    end else if (!packet_done) begin
      shift_strobe <= bit_tick;
      packet_done  <= last_bit;
    end else begin
      shift_strobe <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_timer.sv
module tb_rx_timer;

  logic clk = 1'b0;
  logic n_rst;
  logic en, en2;
  logic strobe, done;
  logic strobe2, done2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rx_timer u_dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable_timer (en),
    .shift_strobe (strobe),
    .packet_done  (done)
  );

  rx_timer #(.CLKS_PER_BIT(4), .BITS_PER_PACKET(2)) u_small (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable_timer (en2),
    .shift_strobe (strobe2),
    .packet_done  (done2)
  );

  // Wait for the next rising edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_edge(input string name);
    en = 1'b0;
    tick();
    checks++;
    if (strobe !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL %s idle: strobe=%b done=%b expected 0/0", name, strobe, done);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; en = 1'b1; en2 = 1'b1;
    for (int e = 1; e <= 2; e++) begin
      tick();
      checks++;
      if (strobe !== 1'b0 || done !== 1'b0 || strobe2 !== 1'b0 || done2 !== 1'b0) begin
        failures++;
        $display("FAIL reset edge=%0d: strobe=%b done=%b strobe2=%b done2=%b expected all 0",
                 e, strobe, done, strobe2, done2);
      end
    end
    en2 = 1'b0;
    n_rst = 1'b1;
    // After release the first strobe is 10 edges away, so nothing yet.
    for (int e = 1; e <= 5; e++) begin
      tick();
      checks++;
      if (strobe !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL reset_after edge=%0d: strobe=%b done=%b expected 0/0", e, strobe, done);
      end
    end
    idle_edge("reset");
  endtask

  // Full packet then 30 hold edges, drop enable once, then a second packet.
  task automatic test_full_hold_rearm();
    int nstrobe;
    logic es, ed;
    nstrobe = 0;
    en = 1'b1;
    for (int e = 1; e <= 120; e++) begin
      tick();
      es = (e % 10 == 0) && (e <= 90);
      ed = (e >= 90);
      if (strobe === 1'b1) nstrobe++;
      checks++;
      if (strobe !== es || done !== ed) begin
        failures++;
        $display("FAIL full_hold edge=%0d: strobe=%b done=%b expected %b/%b", e, strobe, done, es, ed);
      end
    end
    checks++;
    if (nstrobe != 9) begin
      failures++;
      $display("FAIL strobe_count: got %0d expected 9", nstrobe);
    end
    idle_edge("hold_release");
    en = 1'b1;
    for (int e = 1; e <= 95; e++) begin
      tick();
      es = (e % 10 == 0) && (e <= 90);
      ed = (e >= 90);
      checks++;
      if (strobe !== es || done !== ed) begin
        failures++;
        $display("FAIL back_to_back edge=%0d: strobe=%b done=%b expected %b/%b", e, strobe, done, es, ed);
      end
    end
    idle_edge("back_to_back");
  endtask

  // Enable low at edges 45,46; high again from 47.
  task automatic test_abort();
    logic es, ed;
    int k;
    for (int e = 1; e <= 140; e++) begin
      en = !(e == 45 || e == 46);
      tick();
      if (e < 45) begin
        es = (e % 10 == 0); ed = 1'b0;
      end else if (e < 47) begin
        es = 1'b0; ed = 1'b0;
      end else begin
        k = e - 46;
        es = (k % 10 == 0) && (k <= 90);
        ed = (k >= 90);
      end
      checks++;
      if (strobe !== es || done !== ed) begin
        failures++;
        $display("FAIL abort edge=%0d: strobe=%b done=%b expected %b/%b", e, strobe, done, es, ed);
      end
    end
    idle_edge("abort");
  endtask

  // Reset sampled low at edges 33 and 34, enable high throughout.
  task automatic test_reset_mid();
    logic es, ed;
    int k;
    en = 1'b1;
    for (int e = 1; e <= 130; e++) begin
      n_rst = !(e == 33 || e == 34);
      tick();
      if (e < 33) begin
        es = (e % 10 == 0); ed = 1'b0;
      end else if (e < 35) begin
        es = 1'b0; ed = 1'b0;
      end else begin
        k = e - 34;
        es = (k % 10 == 0) && (k <= 90);
        ed = (k >= 90);
      end
      checks++;
      if (strobe !== es || done !== ed) begin
        failures++;
        $display("FAIL reset_mid edge=%0d: strobe=%b done=%b expected %b/%b", e, strobe, done, es, ed);
      end
    end
    n_rst = 1'b1;
    idle_edge("reset_mid");
  endtask

  task automatic test_small();
    logic es, ed;
    en2 = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      es = (e == 4) || (e == 8);
      ed = (e >= 8);
      checks++;
      if (strobe2 !== es || done2 !== ed) begin
        failures++;
        $display("FAIL small edge=%0d: strobe=%b done=%b expected %b/%b", e, strobe2, done2, es, ed);
      end
    end
    en2 = 1'b0;
    tick();
    checks++;
    if (strobe2 !== 1'b0 || done2 !== 1'b0) begin
      failures++;
      $display("FAIL small_idle: strobe=%b done=%b expected 0/0", strobe2, done2);
    end
  endtask

  initial begin
    n_rst = 1'b0; en = 1'b0; en2 = 1'b0;
    #1;
    test_reset();
    test_full_hold_rearm();
    test_abort();
    test_reset_mid();
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
